// File: rtl/eth_audio_rx.sv
// Receive end of the PDM-audio-over-Ethernet link: validates audio packets, double-buffers the PCM and replays one frame per pcm_stb.
// Optional build macro ETHERTYPE_CHECK_EN: drop packets whose bytes 12..13 differ from ETHERTYPE.
module eth_audio_rx #(
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned FRAMES    = 32,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_stb,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    input  logic        pcm_stb,
    output logic        out_stb,
    output logic [3:0]  out_chan,
    output logic [15:0] out_sample,
    output logic        playing,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  underrun_cnt
);
    localparam int unsigned WORDS   = FRAMES * CHANNELS;
    localparam int unsigned DEPTH   = 2 * WORDS;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned FW      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [10:0] PKT_LEN = 11'(14 + 2 * WORDS);
    localparam logic [3:0]  CH_LAST = 4'(CHANNELS - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(FRAMES - 1);
`ifdef ETHERTYPE_CHECK_EN
    localparam bit ET_CHECK = 1'b1;
`else
    localparam bit ET_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, ZERO} play_state_e;

    logic [15:0] mem [DEPTH];
    logic [15:0] rd_data_q;

    logic [10:0] bcnt_q, bcnt_d;
    logic        in_pkt_q, in_pkt_d;
    logic        ovr_q, ovr_d;
    logic        et_bad_q, et_bad_d;
    logic [7:0]  low_q, low_d;
    logic        wr_buf_q, wr_buf_d;
    logic [1:0]  full_q, full_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;
    logic        commit, we;
    logic [10:0] pay_idx;
    logic [15:0] wr_addr_wide;

    play_state_e state_q, state_d;
    logic [3:0]    ch_q, ch_d;
    logic [FW-1:0] rd_frame_q, rd_frame_d;
    logic          rd_buf_q, rd_buf_d;
    logic          playing_q, playing_d;
    logic [7:0]    und_q, und_d;
    logic          emit, emit_zero, re, release_buf;
    logic [15:0]   rd_addr_wide;

    logic        out_stb_q;
    logic [3:0]  out_chan_q;
    logic        sample_zero_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bcnt_d       = bcnt_q;
        in_pkt_d     = in_pkt_q;
        ovr_d        = ovr_q;
        et_bad_d     = et_bad_q;
        low_d        = low_q;
        wr_buf_d     = wr_buf_q;
        commit       = 1'b0;
        we           = 1'b0;
        drop_inc     = 2'd0;
        pay_idx      = bcnt_q - 11'd14;
        wr_addr_wide = 16'(pay_idx[10:1]) + (wr_buf_q ? 16'(WORDS) : 16'd0);
        if (rx_stb) begin
            if (rx_sof) begin
                // An abandoned packet is counted once; an overrun one was already counted at its sof.
                if (in_pkt_q && !ovr_q) drop_inc = drop_inc + 2'd1;
                if (full_q[wr_buf_q]) drop_inc = drop_inc + 2'd1;
                in_pkt_d = 1'b1;
                ovr_d    = full_q[wr_buf_q];
                et_bad_d = 1'b0;
                bcnt_d   = 11'd1;
            end else if (in_pkt_q && !ovr_q) begin
                bcnt_d = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
                if (bcnt_q == 11'd12 && ET_CHECK && rx_data != ETHERTYPE[15:8]) et_bad_d = 1'b1;
                if (bcnt_q == 11'd13 && ET_CHECK && rx_data != ETHERTYPE[7:0])  et_bad_d = 1'b1;
                if (bcnt_q >= 11'd14) begin
                    if (!pay_idx[0]) low_d = rx_data;
                    else if (16'(pay_idx[10:1]) < 16'(WORDS)) we = !et_bad_q;
                end
            end
            if (rx_eof) begin
                if (in_pkt_d && !ovr_d) begin
                    if (!rx_err && bcnt_d == PKT_LEN && !et_bad_d) commit = 1'b1;
                    else drop_inc = drop_inc + 2'd1;
                end
                in_pkt_d = 1'b0;
            end
        end
        if (commit) wr_buf_d = !wr_buf_q;
        drop_sum   = {1'b0, drop_cnt_q} + 9'(drop_inc);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        rd_frame_d   = rd_frame_q;
        rd_buf_d     = rd_buf_q;
        und_d        = und_q;
        emit         = 1'b0;
        emit_zero    = 1'b0;
        re           = 1'b0;
        release_buf  = 1'b0;
        rd_addr_wide = 16'(rd_frame_q) * 16'(CHANNELS) + 16'(ch_q)
                     + (rd_buf_q ? 16'(WORDS) : 16'd0);
        case (state_q)
            IDLE: begin
                if (pcm_stb) begin
                    ch_d = '0;
                    if (full_q[rd_buf_q]) begin
                        state_d = READ;
                    end else begin
                        state_d = ZERO;
                        if (und_q != 8'hFF) und_d = und_q + 8'd1;
                    end
                end
            end
            READ, ZERO: begin
                emit      = 1'b1;
                emit_zero = (state_q == ZERO);
                re        = (state_q == READ);
                ch_d      = ch_q + 4'd1;
                if (ch_q == CH_LAST) begin
                    state_d = IDLE;
                    ch_d    = '0;
                    if (state_q == READ) begin
                        if (rd_frame_q == FR_LAST) begin
                            release_buf = 1'b1;
                            rd_frame_d  = '0;
                            rd_buf_d    = !rd_buf_q;
                        end else begin
                            rd_frame_d = rd_frame_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writer commit and player release never target the same buffer, so both apply.
    always_comb begin
        full_d    = full_q;
        playing_d = playing_q;
        if (release_buf) full_d[rd_buf_q] = 1'b0;
        if (commit) full_d[wr_buf_q] = 1'b1;
        if (state_q == IDLE && pcm_stb && full_q[rd_buf_q]) playing_d = 1'b1;
        if (release_buf) playing_d = full_d[!rd_buf_q];
    end

    // NOTE: the sample RAM and its read register carry no reset so they map onto block RAM;
    // playback is gated by full, and out_sample is forced to zero after reset.
    always_ff @(posedge clk) begin
        if (we) mem[AW'(wr_addr_wide)] <= {rx_data, low_q};
        if (re) rd_data_q <= mem[AW'(rd_addr_wide)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q        <= '0;
            in_pkt_q      <= 1'b0;
            ovr_q         <= 1'b0;
            et_bad_q      <= 1'b0;
            low_q         <= '0;
            wr_buf_q      <= 1'b0;
            full_q        <= '0;
            drop_cnt_q    <= '0;
            state_q       <= IDLE;
            ch_q          <= '0;
            rd_frame_q    <= '0;
            rd_buf_q      <= 1'b0;
            playing_q     <= 1'b0;
            und_q         <= '0;
            out_stb_q     <= 1'b0;
            out_chan_q    <= '0;
            sample_zero_q <= 1'b1;
        end else begin
            bcnt_q     <= bcnt_d;
            in_pkt_q   <= in_pkt_d;
            ovr_q      <= ovr_d;
            et_bad_q   <= et_bad_d;
            low_q      <= low_d;
            wr_buf_q   <= wr_buf_d;
            full_q     <= full_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            ch_q       <= ch_d;
            rd_frame_q <= rd_frame_d;
            rd_buf_q   <= rd_buf_d;
            playing_q  <= playing_d;
            und_q      <= und_d;
            out_stb_q  <= emit;
            if (emit) begin
                out_chan_q    <= ch_q;
                sample_zero_q <= emit_zero;
            end
        end
    end

    assign out_stb      = out_stb_q;
    assign out_chan     = out_chan_q;
    assign out_sample   = sample_zero_q ? 16'd0 : rd_data_q;
    assign playing      = playing_q;
    assign drop_cnt     = drop_cnt_q;
    assign underrun_cnt = und_q;

endmodule

// File: tb/tb_eth_audio_rx.sv
// Randomized self-checking bench for eth_audio_rx against a packet-queue reference model.
// The model treats the two buffers as a FIFO of accepted packets, replayed one frame per pcm_stb.
module tb_eth_audio_rx;
    localparam int CH      = 8;
    localparam int FR      = 32;
    localparam int WORDS   = CH * FR;
    localparam int PKT_LEN = 14 + 2 * WORDS;
    localparam logic [15:0] ET_AUDIO = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_stb, rx_sof, rx_eof, rx_err, pcm_stb;
    logic [7:0]  rx_data;
    logic        out_stb, playing;
    logic [3:0]  out_chan;
    logic [15:0] out_sample;
    logic [7:0]  drop_cnt, underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] pay [WORDS];
    logic [15:0] exp_words [$];
    int exp_nbuf, exp_frame, exp_drop, exp_und;
    bit exp_playing, open_counts;

    eth_audio_rx #(.CHANNELS(CH), .FRAMES(FR), .ETHERTYPE(ET_AUDIO)) dut (
        .clk(clk), .rst(rst),
        .rx_stb(rx_stb), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
        .pcm_stb(pcm_stb),
        .out_stb(out_stb), .out_chan(out_chan), .out_sample(out_sample),
        .playing(playing), .drop_cnt(drop_cnt), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        exp_words.delete();
        exp_nbuf    = 0;
        exp_frame   = 0;
        exp_drop    = 0;
        exp_und     = 0;
        exp_playing = 1'b0;
        open_counts = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
        check({tag, "_underrun"}, 32'(underrun_cnt), 32'(exp_und));
    endtask

    // One byte strobe; qualifier inputs carry noise while rx_stb is low.
    task automatic drive_byte(input logic [7:0] d, input bit sof, input bit eof, input bit err);
        @(posedge clk); #1;
        rx_stb = 1'b1; rx_data = d; rx_sof = sof; rx_eof = eof; rx_err = err;
        @(posedge clk); #1;
        rx_stb = 1'b0; rx_data = 8'($urandom);
        rx_sof = 1'($urandom); rx_eof = 1'($urandom); rx_err = 1'($urandom);
        if ($urandom_range(0, 3) == 0) @(posedge clk);
    endtask

    // Sends a packet of len bytes (or only the first cut bytes with no eof) from pay[].
    task automatic send_pkt(input int len, input bit err, input int cut, input logic [15:0] et);
        bit ovr, ok;
        int n, p;
        logic [7:0] b;
        if (open_counts) exp_drop = sat(exp_drop + 1);
        ovr = (exp_nbuf == 2);
        if (ovr) exp_drop = sat(exp_drop + 1);
        n = (cut > 0) ? cut : len;
        for (int i = 0; i < n; i++) begin
            if (i == 12)      b = et[15:8];
            else if (i == 13) b = et[7:0];
            else if (i < 14)  b = 8'($urandom);
            else begin
                p = i - 14;
                if (p / 2 < WORDS) b = (p % 2 == 0) ? pay[p / 2][7:0] : pay[p / 2][15:8];
                else b = 8'($urandom);
            end
            drive_byte(b, i == 0, cut == 0 && i == n - 1, err && cut == 0 && i == n - 1);
        end
        if (cut > 0) begin
            open_counts = !ovr;
        end else begin
            open_counts = 1'b0;
            ok = !err && len == PKT_LEN;
`ifdef ETHERTYPE_CHECK_EN
            if (et != ET_AUDIO) ok = 1'b0;
`endif
            if (!ovr) begin
                if (ok) begin
                    for (int w = 0; w < WORDS; w++) exp_words.push_back(pay[w]);
                    exp_nbuf++;
                end else begin
                    exp_drop = sat(exp_drop + 1);
                end
            end
        end
    endtask

    // One pcm_stb and the full output window that follows it.
    task automatic do_pcm(input bit extra);
        logic [15:0] smp [CH];
        bit have;
        have = (exp_nbuf > 0);
        for (int c = 0; c < CH; c++) smp[c] = have ? exp_words.pop_front() : 16'd0;
        if (have) begin
            exp_playing = 1'b1;
            exp_frame++;
            if (exp_frame == FR) begin
                exp_frame   = 0;
                exp_nbuf--;
                exp_playing = (exp_nbuf > 0);
            end
        end else begin
            exp_und = sat(exp_und + 1);
        end
        @(posedge clk); #1; pcm_stb = 1'b1;
        @(posedge clk); #1; pcm_stb = 1'b0;
        @(negedge clk);
        check("stb_early", 32'(out_stb), 32'd0);
        for (int c = 0; c < CH; c++) begin
            @(posedge clk); #1; pcm_stb = extra && (c == 0);
            @(negedge clk);
            check("stb", 32'(out_stb), 32'd1);
            check("chan", 32'(out_chan), 32'(c));
            check("sample", 32'(out_sample), 32'(smp[c]));
        end
        @(posedge clk); #1; pcm_stb = 1'b0;
        @(negedge clk);
        check("stb_late", 32'(out_stb), 32'd0);
        check("chan_hold", 32'(out_chan), 32'(CH - 1));
        check("sample_hold", 32'(out_sample), 32'(smp[CH - 1]));
        check("playing", 32'(playing), 32'(exp_playing));
        check("underrun", 32'(underrun_cnt), 32'(exp_und));
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic fill_ramp();
        for (int w = 0; w < WORDS; w++) pay[w] = 16'((w / CH) * 256 + (w % CH));
    endtask

    task automatic fill_rand();
        for (int w = 0; w < WORDS; w++) pay[w] = 16'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stb"}, 32'(out_stb), 32'd0);
        check({tag, "_chan"}, 32'(out_chan), 32'd0);
        check({tag, "_sample"}, 32'(out_sample), 32'd0);
        check({tag, "_playing"}, 32'(playing), 32'd0);
        check_counts(tag);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int kind;
        bit last_cut;
        rst = 1'b1; rx_stb = 1'b0; rx_data = '0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
        pcm_stb = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Ramp packet, played out completely.
        fill_ramp();
        send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        repeat (FR) do_pcm(1'b0);
        check("playing_done", 32'(playing), 32'd0);
        check_counts("ramp");

        // Underrun with nothing buffered.
        do_pcm(1'b0);
        check_counts("underrun1");

        // Three packets back to back: third overruns.
        fill_rand(); send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        fill_rand(); send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        fill_rand(); send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        check_counts("overrun");
        repeat (2 * FR) do_pcm($urandom_range(0, 1) == 1);

        // Short packet, errored packet, then an abandoned packet restarted in full.
        fill_rand();
        send_pkt(PKT_LEN - 1, 1'b0, 0, ET_AUDIO);
        send_pkt(PKT_LEN, 1'b1, 0, ET_AUDIO);
        do_pcm(1'b0);
        send_pkt(PKT_LEN, 1'b0, 100, ET_AUDIO);
        send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        check_counts("bad_pkts");
        repeat (FR) do_pcm(1'b0);

        // Reset in the middle of a packet.
        fill_rand();
        send_pkt(PKT_LEN, 1'b0, 200, ET_AUDIO);
        pulse_reset();
        check_reset_outputs("rst_pkt");

        // Reset during a READ burst, part way through a buffer.
        fill_rand();
        send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        repeat (5) do_pcm(1'b0);
        @(posedge clk); #1; pcm_stb = 1'b1;
        @(posedge clk); #1; pcm_stb = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("stb_before_rst", 32'(out_stb), 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("rst_read");
        fill_ramp();
        send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        repeat (FR) do_pcm(1'b0);

        // Randomized mix of good and bad packets and replay.
        last_cut = 1'b0;
        repeat (8) begin
            fill_rand();
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1:    send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
                2:       send_pkt(PKT_LEN + $urandom_range(1, 10), 1'b0, 0, ET_AUDIO);
                3:       send_pkt(PKT_LEN, 1'b1, 0, ET_AUDIO);
                4:       send_pkt(PKT_LEN, 1'b0, $urandom_range(20, 500), ET_AUDIO);
                default: send_pkt(PKT_LEN - $urandom_range(1, 20), 1'b0, 0, ET_AUDIO);
            endcase
            last_cut = (kind == 4);
            if (!last_cut && $urandom_range(0, 1) == 1)
                drive_byte(8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            check_counts("rand_pkt");
            repeat ($urandom_range(0, 40)) do_pcm($urandom_range(0, 3) == 0);
        end
        while (exp_nbuf > 0) do_pcm(1'b0);
        check_counts("rand_end");

        // EtherType handling: foreign type then audio type.
        fill_rand();
        send_pkt(PKT_LEN, 1'b0, 0, 16'h0800);
        check_counts("et_ip");
        fill_rand();
        send_pkt(PKT_LEN, 1'b0, 0, ET_AUDIO);
        check_counts("et_audio");
        while (exp_nbuf > 0) do_pcm(1'b0);
        check("playing_final", 32'(playing), 32'd0);
        check_counts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_audio_rx.md
Name: eth_audio_rx

Overview:
- Receive end of the multichannel PDM-audio-over-Ethernet link: consumes the byte stream of a raw Ethernet receiver, validates each audio frame, and double-buffers the 16-bit PCM payload.
- Replays the PCM one frame per local pcm_stb as a per-channel sample stream for a DAC/PDM modulator.
- Packet layout: 14 header bytes, then FRAMES sample frames. Each frame is channel 0..CHANNELS-1; each sample is low byte then high byte.

Parameters:
- CHANNELS, 8, channels per sample frame (1..16)
- FRAMES, 32, sample frames per packet
- ETHERTYPE, 16'h88B5, expected bytes 12..13, big-endian; used only with ETHERTYPE_CHECK_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_stb  in  1  one-cycle strobe: rx_data valid
- rx_data  in  8  received byte
- rx_sof  in  1  qualifies rx_stb: first byte of frame
- rx_eof  in  1  qualifies rx_stb: last byte of frame
- rx_err  in  1  qualifies rx_stb with rx_eof: FCS/PHY error on frame
- pcm_stb  in  1  local sample-rate strobe; pulses at least CHANNELS+3 cycles apart
- out_stb  out  1  one-cycle strobe: out_sample valid
- out_chan  out  4  channel index of out_sample
- out_sample  out  16  PCM sample, two's complement
- playing  out  1  a buffer is being replayed
- drop_cnt  out  8  packets rejected, saturating
- underrun_cnt  out  8  pcm_stb with no data, saturating

Behaviour:
- Storage: one 2*FRAMES*CHANNELS x 16 RAM, split into buffers 0 and 1, registered read with 1-cycle latency. State: full[1:0], wr_buf, rd_buf, rd_frame.
- Writer: byte counter bcnt (11 bits, saturating at 2047).
  - rx_stb&rx_sof: bcnt<=1.
  - If full[wr_buf]=1: packet dropped (overrun), drop_cnt++; bytes ignored until next sof.
  - Payload byte p=bcnt-14: even p latched as low byte; odd p writes {rx_data,low} to wr_buf at word p>>1.
  - Writes suppressed when p>>1 >= FRAMES*CHANNELS.
- Commit on rx_stb&rx_eof: accept iff not dropped, !rx_err, and final byte count == 14+2*FRAMES*CHANNELS (default 526).
  - Accept: full[wr_buf]<=1, wr_buf toggles.
  - Reject: drop_cnt++; buffer contents are don't-care and remain empty.
- New sof before eof: current packet abandoned, drop_cnt++, new packet starts.
- Bytes between eof and the next sof are ignored.
- Player FSM:
  - IDLE: on pcm_stb go to READ if full[rd_buf], else to ZERO and underrun_cnt++.
  - READ: issue reads for channels 0..CHANNELS-1 of rd_frame on consecutive cycles.
  - ZERO: emit the same strobe pattern with out_sample=0.
- Output timing: for pcm_stb at cycle N, out_stb is high at N+2..N+1+CHANNELS with out_chan=c at N+2+c. out_stb is low otherwise; out_chan/out_sample hold their last value.
- pcm_stb while not IDLE is ignored; underrun_cnt is not incremented.
- After channel CHANNELS-1 of frame FRAMES-1: full[rd_buf]<=0, rd_buf toggles, rd_frame<=0. Otherwise rd_frame++.
- playing=1 from the first READ of a buffer until its release, continuing if the next buffer is already full.
- Same-cycle writer commit and player release always hit different buffers; both take effect.
- Counters saturate at 255.
- Reset:
  - Outputs zero; full=0, wr_buf=rd_buf=0, rd_frame=0, bcnt=0.
  - Writer waits for next sof (a packet in progress is discarded, not counted); player goes to IDLE.
  - RAM contents are not cleared.

Optional Feature:
- Macro ETHERTYPE_CHECK_EN.
- Defined: bytes 12 and 13 are compared to ETHERTYPE[15:8] and ETHERTYPE[7:0]. On mismatch the packet is dropped, drop_cnt++ at eof, no buffer is written, and full is unchanged.
- Undefined: header bytes 0..13 are ignored entirely and ETHERTYPE is unused.

Test Plan:
- Sample value = frame*256+chan. One valid 526-byte packet, then 32 pcm_stb -> 256 out_stb, in order, with matching values. playing drops after the last sample; drop_cnt=0, underrun_cnt=0.
- pcm_stb with no packet received -> 8 out_stb, out_sample=0, out_chan 0..7 at N+2..N+9; underrun_cnt=1.
- Three valid packets back to back with no pcm_stb -> first two accepted, third dropped, drop_cnt=1. Replay yields packet 1 then packet 2 data.
- Packet of 525 bytes; then packet with rx_err at eof; then sof injected at byte 100 of a packet -> drop_cnt=3, full=0, and the restarted packet is accepted if complete.
- rst asserted mid-packet and during READ -> outputs 0 next cycle, counters 0. The next valid packet plays from frame 0.
- With ETHERTYPE_CHECK_EN: bytes 12..13=0x0800 -> dropped, drop_cnt=1; 0x88B5 -> accepted.
